// File: rtl/mux21_sync_pkg.sv
// Shared constants for the mux21_sync selector: reset default and select encoding.
package mux21_sync_pkg;

  // Bit replicated across WIDTH to form the default out_q reset value.
  localparam logic DEFAULT_RST_BIT = 1'b0;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage : mux21_sync_pkg

// File: rtl/mux21_sync_if.sv
// Operand/result bundle for mux21_sync; master drives operands, slave returns results.
interface mux21_sync_if #(
  parameter int WIDTH = 1
) ();

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic             in_valid;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             out_valid;
  logic             sel_q;

  modport master (
    output a, b, sel, in_valid,
    input  out, out_q, out_valid, sel_q
  );

  modport slave (
    input  a, b, sel, in_valid,
    output out, out_q, out_valid, sel_q
  );

endinterface : mux21_sync_if

// File: rtl/mux21_comb.sv
// Pure combinational WIDTH-bit 2:1 selector; an unknown select merges a/b per bit.
module mux21_comb
  import mux21_sync_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit
      // Conditional operator keeps agreeing bits known when sel is X.
      assign y[gi] = (sel == SEL_B) ? b[gi] : a[gi];
    end
  endgenerate

endmodule : mux21_comb

// File: rtl/mux21_sync.sv
// 2:1 multiplexer with a zero-latency output and a one-cycle registered output + valid.
module mux21_sync
  import mux21_sync_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{DEFAULT_RST_BIT}}
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  mux21_sync_if.slave  bus
);

  logic [WIDTH-1:0] mux_y;
  logic [WIDTH-1:0] out_q_reg;
  logic             sel_q_reg;
  logic             out_valid_reg;

  // Single selector shared by the combinational output and the capture register.
  mux21_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .a   (bus.a),
    .b   (bus.b),
    .sel (bus.sel),
    .y   (mux_y)
  );

  assign bus.out = mux_y;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_q_reg     <= RST_VAL;
      sel_q_reg     <= SEL_A;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        out_q_reg <= mux_y;
        sel_q_reg <= bus.sel;
      end
    end
  end

  assign bus.out_q     = out_q_reg;
  assign bus.sel_q     = sel_q_reg;
  assign bus.out_valid = out_valid_reg;

endmodule : mux21_sync

// File: tb/tb_mux21_sync.sv
// Self-checking bench for mux21_sync: directed plan items plus randomized traffic.
module tb_mux21_sync;

  localparam logic [7:0] RST8 = 8'h5A;

  logic sys_clk;
  logic sys_rst_n;

  mux21_sync_if #(.WIDTH(8)) bus8 ();
  mux21_sync_if #(.WIDTH(1)) bus1 ();

  mux21_sync #(.WIDTH(8), .RST_VAL(RST8)) dut8 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus8)
  );

  mux21_sync #(.WIDTH(1)) dut1 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus1)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int passed = 0;
  int total  = 0;

  // Reference state for the 8-bit registered path.
  logic [7:0] exp_q;
  logic       exp_sel_q;
  logic       exp_valid;

  function automatic logic [7:0] pick(input logic [7:0] a, input logic [7:0] b, input logic s);
    return s ? b : a;
  endfunction

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic s, input logic v);
    @(negedge sys_clk);
    bus8.a = a; bus8.b = b; bus8.sel = s; bus8.in_valid = v;
  endtask

  // Advance one rising edge, apply the reference rules, then settle before sampling.
  task automatic cycle();
    @(posedge sys_clk);
    if (!sys_rst_n) begin
      exp_q = RST8; exp_sel_q = 1'b0; exp_valid = 1'b0;
    end else if (bus8.in_valid) begin
      exp_q = pick(bus8.a, bus8.b, bus8.sel); exp_sel_q = bus8.sel; exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    #3 sys_rst_n = 1'b0;
    #1;
    exp_q = RST8; exp_sel_q = 1'b0; exp_valid = 1'b0;
    total++; if (bus8.out_q !== RST8) $display("FAIL reset_out_q got=%h exp=%h", bus8.out_q, RST8); else passed++;
    total++; if (bus8.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus8.out_valid); else passed++;
    total++; if (bus8.sel_q !== 1'b0) $display("FAIL reset_sel_q got=%b exp=0", bus8.sel_q); else passed++;
    total++; if (bus1.out_q !== 1'b0) $display("FAIL reset_out_q_w1 got=%b exp=0", bus1.out_q); else passed++;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    $display("reset: out_q=%h out_valid=%b sel_q=%b", bus8.out_q, bus8.out_valid, bus8.sel_q);
  endtask

  task automatic test_comb_width1();
    logic [7:0] table_bits;
    logic [2:0] idx;
    table_bits = 8'hD8;  // bit index = {a,b,sel}
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      bus1.a = idx[2]; bus1.b = idx[1]; bus1.sel = idx[0];
      #200;
      total++;
      if (bus1.out !== table_bits[i]) $display("FAIL comb_w1 abs=%b got=%b exp=%b", idx, bus1.out, table_bits[i]);
      else passed++;
      $display("comb_w1: a=%b b=%b sel=%b out=%b", bus1.a, bus1.b, bus1.sel, bus1.out);
    end
  endtask

  task automatic test_registered_basic();
    drive(8'hA5, 8'h3C, 1'b0, 1'b1);
    #1;
    total++; if (bus8.out !== 8'hA5) $display("FAIL basic_comb_sel0 got=%h exp=a5", bus8.out); else passed++;
    cycle();
    total++; if (bus8.out_q !== 8'hA5) $display("FAIL basic_out_q_sel0 got=%h exp=a5", bus8.out_q); else passed++;
    total++; if (bus8.out_valid !== 1'b1) $display("FAIL basic_valid_sel0 got=%b exp=1", bus8.out_valid); else passed++;
    drive(8'hA5, 8'h3C, 1'b1, 1'b1);
    cycle();
    total++; if (bus8.out_q !== 8'h3C) $display("FAIL basic_out_q_sel1 got=%h exp=3c", bus8.out_q); else passed++;
    total++; if (bus8.sel_q !== 1'b1) $display("FAIL basic_sel_q got=%b exp=1", bus8.sel_q); else passed++;
    $display("basic: out_q=%h sel_q=%b out_valid=%b", bus8.out_q, bus8.sel_q, bus8.out_valid);
  endtask

  task automatic test_accept_idle();
    logic [7:0] ra, rb;
    logic       rs;
    drive(8'h00, 8'h7E, 1'b1, 1'b1);
    cycle();
    total++; if (bus8.out_valid !== 1'b1) $display("FAIL idle_accept_valid got=%b exp=1", bus8.out_valid); else passed++;
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      drive(ra, rb, rs, 1'b0);
      #1;
      total++; if (bus8.out !== pick(ra, rb, rs)) $display("FAIL idle_comb got=%h exp=%h", bus8.out, pick(ra, rb, rs)); else passed++;
      cycle();
      total++; if (bus8.out_valid !== 1'b0) $display("FAIL idle_valid got=%b exp=0", bus8.out_valid); else passed++;
      total++; if (bus8.out_q !== 8'h7E) $display("FAIL idle_out_q got=%h exp=7e", bus8.out_q); else passed++;
      $display("idle: out=%h out_q=%h out_valid=%b", bus8.out, bus8.out_q, bus8.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(8'($urandom), 8'($urandom), 1'b1, 1'b1);
      cycle();
    end
    #2 sys_rst_n = 1'b0;
    #1;
    exp_q = RST8; exp_sel_q = 1'b0; exp_valid = 1'b0;
    total++; if (bus8.out_q !== RST8) $display("FAIL mid_rst_out_q got=%h exp=%h", bus8.out_q, RST8); else passed++;
    total++; if (bus8.out_valid !== 1'b0) $display("FAIL mid_rst_valid got=%b exp=0", bus8.out_valid); else passed++;
    total++; if (bus8.sel_q !== 1'b0) $display("FAIL mid_rst_sel_q got=%b exp=0", bus8.sel_q); else passed++;
    total++; if (bus8.out !== bus8.b) $display("FAIL mid_rst_comb got=%h exp=%h", bus8.out, bus8.b); else passed++;
    drive(8'h44, 8'h99, 1'b0, 1'b1);
    cycle();
    total++; if (bus8.out_valid !== 1'b0) $display("FAIL mid_rst_hold_valid got=%b exp=0", bus8.out_valid); else passed++;
    total++; if (bus8.out_q !== RST8) $display("FAIL mid_rst_hold_out_q got=%h exp=%h", bus8.out_q, RST8); else passed++;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    bus8.a = 8'hC3; bus8.b = 8'h12; bus8.sel = 1'b1; bus8.in_valid = 1'b1;
    cycle();
    total++; if (bus8.out_q !== 8'h12) $display("FAIL mid_rst_first_out_q got=%h exp=12", bus8.out_q); else passed++;
    total++; if (bus8.out_valid !== 1'b1) $display("FAIL mid_rst_first_valid got=%b exp=1", bus8.out_valid); else passed++;
    $display("reset_mid: out_q=%h out_valid=%b sel_q=%b", bus8.out_q, bus8.out_valid, bus8.sel_q);
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [4];
    seq = '{8'h11, 8'h22, 8'h11, 8'h22};
    for (int i = 0; i < 4; i++) begin
      drive(8'h11, 8'h22, 1'(i % 2), 1'b1);
      cycle();
      total++; if (bus8.out_q !== seq[i]) $display("FAIL b2b_out_q[%0d] got=%h exp=%h", i, bus8.out_q, seq[i]); else passed++;
      total++; if (bus8.out_valid !== 1'b1) $display("FAIL b2b_valid[%0d] got=%b exp=1", i, bus8.out_valid); else passed++;
      $display("b2b: out_q=%h out_valid=%b", bus8.out_q, bus8.out_valid);
    end
    drive(8'h11, 8'h22, 1'b0, 1'b0);
    cycle();
    total++; if (bus8.out_valid !== 1'b0) $display("FAIL b2b_end_valid got=%b exp=0", bus8.out_valid); else passed++;
  endtask

  task automatic test_random();
    logic [7:0] ra, rb;
    logic       rs, rv;
    for (int i = 0; i < 64; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); rv = ($urandom_range(0, 3) != 0);
      drive(ra, rb, rs, rv);
      #1;
      total++; if (bus8.out !== pick(ra, rb, rs)) $display("FAIL rand_comb got=%h exp=%h", bus8.out, pick(ra, rb, rs)); else passed++;
      cycle();
      total++; if (bus8.out_q !== exp_q) $display("FAIL rand_out_q got=%h exp=%h", bus8.out_q, exp_q); else passed++;
      total++; if (bus8.out_valid !== exp_valid) $display("FAIL rand_valid got=%b exp=%b", bus8.out_valid, exp_valid); else passed++;
      total++; if (bus8.sel_q !== exp_sel_q) $display("FAIL rand_sel_q got=%b exp=%b", bus8.sel_q, exp_sel_q); else passed++;
      $display("rand: a=%h b=%h sel=%b v=%b out_q=%h out_valid=%b", ra, rb, rs, rv, bus8.out_q, bus8.out_valid);
    end
  endtask

  initial begin
    sys_rst_n = 1'b1;
    bus8.a = '0; bus8.b = '0; bus8.sel = 1'b0; bus8.in_valid = 1'b0;
    bus1.a = '0; bus1.b = '0; bus1.sel = 1'b0; bus1.in_valid = 1'b0;
    exp_q = RST8; exp_sel_q = 1'b0; exp_valid = 1'b0;
    test_reset();
    test_comb_width1();
    test_registered_basic();
    test_accept_idle();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_mux21_sync
